// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks a synchronous RAM one word at a time and registers
// each {address, data} pair for the HEX display path.
// Latency: rd_en one cycle after the trigger; disp_valid RD_LATENCY+1 cycles after rd_en.
// Backpressure: none. Triggers that arrive while a read is in flight are dropped, not queued.
//
// Ports:
//   clk, reset_n          clock (rising edge) and async active-low reset
//   run                   1 = auto scan on each tick, 0 = manual step mode
//   step                  debounced step request; its rising edge triggers one read
//   rd_en/rd_addr         RAM read strobe (one cycle per read) and scan pointer
//   rd_data               RAM read data, valid RD_LATENCY cycles after rd_en
//   disp_addr/disp_data   address and data of the last completed read
//   disp_valid            one-cycle pulse when disp_addr/disp_data update
//   busy                  high while a read is in flight
module ram_scan_reader #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 4,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  // WAIT lasts RD_LATENCY-1 cycles; the counter starts at 0 on WAIT entry.
  localparam logic [1:0] LAT_LAST = 2'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          step_q;
  logic [1:0]    lat_cnt;
  logic          tick;
  logic          step_edge;

  assign tick      = (tick_cnt == TICK_LAST) && run;
  assign step_edge = step && !step_q;
  assign busy      = (state != IDLE);

  // Free-running tick timer; cleared whenever auto mode is off so the first
  // tick after run rises is a full period away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!run) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      disp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Step edges only count in manual mode; anything seen outside IDLE
          // is simply lost because this is the only state that looks at it.
          if (tick || (step_edge && !run)) begin
            state <= ISSUE;
            rd_en <= 1'b1;
          end
        end
        ISSUE: begin
          rd_en   <= 1'b0;
          lat_cnt <= '0;
          state   <= (RD_LATENCY == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          disp_data  <= rd_data;
          disp_addr  <= rd_addr;
          rd_addr    <= rd_addr + 1'b1;  // natural wrap at 2**ADDR_W
          disp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
module tb_ram_scan_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run1, step1, run2, step2;
  logic       rd_en1, rd_en2, disp_valid1, disp_valid2, busy1, busy2;
  logic [4:0] rd_addr1, rd_addr2, disp_addr1, disp_addr2;
  logic [3:0] rd_data1, rd_data2, disp_data1, disp_data2, pipe2;
  logic [3:0] mem1 [32];
  logic [3:0] mem2 [32];

  int checks   = 0;
  int failures = 0;
  int reads1 = 0, valids1 = 0, reads2 = 0, valids2 = 0;

  always #5 clk = ~clk;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_CYCLES(4), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .run(run1), .step(step1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .disp_addr(disp_addr1), .disp_data(disp_data1),
    .disp_valid(disp_valid1), .busy(busy1)
  );

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_CYCLES(4), .RD_LATENCY(2)) u2 (
    .clk(clk), .reset_n(reset_n), .run(run2), .step(step2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .disp_addr(disp_addr2), .disp_data(disp_data2),
    .disp_valid(disp_valid2), .busy(busy2)
  );

  // Behavioural RAMs: latency 1 (single register) and latency 2 (two stages).
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
    if (rd_en2) pipe2 <= mem2[rd_addr2];
    rd_data2 <= pipe2;
  end

  always @(posedge clk) begin
    if (rd_en1)      reads1  <= reads1 + 1;
    if (disp_valid1) valids1 <= valids1 + 1;
    if (rd_en2)      reads2  <= reads2 + 1;
    if (disp_valid2) valids2 <= valids2 + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int r0, v0, v2, k, waited;
    bit found;
    for (int a = 0; a < 32; a++) begin
      mem1[a] = 4'(a) ^ 4'hA;
      mem2[a] = 4'(a) ^ 4'hA;
    end
    rd_data1 = '0; rd_data2 = '0; pipe2 = '0;
    reset_n = 1'b0;
    run1 = 1'b1; step1 = 1'b0; run2 = 1'b0; step2 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", rd_en1, 0);
    chk("rst_rd_addr", rd_addr1, 0);
    chk("rst_disp_addr", disp_addr1, 0);
    chk("rst_disp_data", disp_data1, 0);
    chk("rst_disp_valid", disp_valid1, 0);
    chk("rst_busy", busy1, 0);

    // Auto scan: 33 ticks, full address wrap
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c <= 134; c++) begin
      @(negedge clk);
      chk($sformatf("auto_rd_en_c%0d", c), rd_en1, int'(c >= 4 && c % 4 == 0));
      chk($sformatf("auto_busy_c%0d", c), busy1, int'(c >= 4 && (c % 4 == 0 || c % 4 == 1)));
      chk($sformatf("auto_valid_c%0d", c), disp_valid1, int'(c >= 6 && c % 4 == 2));
      chk($sformatf("auto_rd_addr_c%0d", c), rd_addr1, (c >= 6) ? (((c - 6) / 4 + 1) % 32) : 0);
      if (disp_valid1) begin
        k = (c - 6) / 4;
        chk($sformatf("auto_disp_addr_k%0d", k), disp_addr1, k % 32);
        chk($sformatf("auto_disp_data_k%0d", k), disp_data1, (k % 16) ^ 'hA);
        if (k == 31) chk("auto_data_at_31", disp_data1, 'h5);
      end
    end
    run1 = 1'b0;
    repeat (6) @(negedge clk);

    // Manual: long step = one read
    r0 = reads1;
    step1 = 1'b1;
    repeat (10) @(negedge clk);
    step1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("step_long_reads", reads1 - r0, 1);

    // Three separate pulses = three reads
    r0 = reads1;
    repeat (3) begin
      step1 = 1'b1;
      @(negedge clk);
      step1 = 1'b0;
      repeat (5) @(negedge clk);
    end
    chk("step_three_reads", reads1 - r0, 3);

    // Pulse while busy is dropped
    r0 = reads1;
    step1 = 1'b1;
    @(negedge clk);
    step1 = 1'b0;
    chk("busy_issue", busy1, 1);
    @(negedge clk);
    chk("busy_capture", busy1, 1);
    step1 = 1'b1;
    @(negedge clk);
    step1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("step_busy_reads", reads1 - r0, 1);
    chk("step_busy_disp_addr", disp_addr1, 5);
    chk("step_busy_disp_data", disp_data1, 'hF);

    // Latency-2 instance: one step, data change at T+1 must not be captured
    step2 = 1'b1;
    @(negedge clk);                       // cycle T
    step2 = 1'b0;
    chk("l2_rd_en_T", rd_en2, 1);
    chk("l2_busy_T", busy2, 1);
    chk("l2_rd_addr_T", rd_addr2, 0);
    @(negedge clk);                       // T+1
    mem2[0] = 4'h3;
    chk("l2_rd_en_T1", rd_en2, 0);
    chk("l2_busy_T1", busy2, 1);
    @(negedge clk);                       // T+2
    chk("l2_busy_T2", busy2, 1);
    chk("l2_valid_T2", disp_valid2, 0);
    @(negedge clk);                       // T+3
    chk("l2_valid_T3", disp_valid2, 1);
    chk("l2_busy_T3", busy2, 0);
    chk("l2_disp_addr", disp_addr2, 0);
    chk("l2_disp_data", disp_data2, 'hA);
    @(negedge clk);
    chk("l2_valid_T4", disp_valid2, 0);
    chk("l2_rd_addr_next", rd_addr2, 1);

    // Reset mid-read (u1 in CAPTURE, u2 in WAIT)
    step1 = 1'b1; step2 = 1'b1;
    @(negedge clk);
    step1 = 1'b0; step2 = 1'b0;
    chk("mid_busy1", busy1, 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_en1", rd_en1, 0);
    chk("mid_rst_rd_addr1", rd_addr1, 0);
    chk("mid_rst_disp_addr1", disp_addr1, 0);
    chk("mid_rst_disp_data1", disp_data1, 0);
    chk("mid_rst_valid1", disp_valid1, 0);
    chk("mid_rst_busy1", busy1, 0);
    chk("mid_rst_busy2", busy2, 0);
    chk("mid_rst_rd_addr2", rd_addr2, 0);
    chk("mid_rst_disp_data2", disp_data2, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    v0 = valids1; v2 = valids2;
    repeat (10) @(negedge clk);
    chk("post_rst_valids1", valids1 - v0, 0);
    chk("post_rst_valids2", valids2 - v2, 0);
    step1 = 1'b1;
    @(negedge clk);
    step1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_read_valids", valids1 - v0, 1);
    chk("post_rst_disp_addr", disp_addr1, 0);
    chk("post_rst_disp_data", disp_data1, 'hA);

    // run 1 -> 0 in the ISSUE cycle
    run1 = 1'b1;
    found = 1'b0;
    waited = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      @(negedge clk);
      if (rd_en1) begin
        found = 1'b1;
        waited = i;
      end
    end
    chk("run_first_tick_found", int'(found), 1);
    chk("run_first_tick_delay", waited, 4);
    run1 = 1'b0;
    r0 = reads1; v0 = valids1;
    repeat (20) @(negedge clk);
    chk("run_drop_reads", reads1 - r0, 1);
    chk("run_drop_valids", valids1 - v0, 1);
    chk("run_drop_disp_addr", disp_addr1, 1);
    chk("run_drop_disp_data", disp_data1, 'hB);
    chk("run_drop_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
